inst_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the execute/GPR stage. Owns the program counter and reads 32-bit instruction words from a synchronous instruction memory. Presents each word as IR to the execute stage over a valid/ready handshake, and accepts branch redirects from execute. Stops permanently on a HALT opcode until reset.

---
 rtl/inst_fetch_unit.sv | 91 +++++++++
 tb/tb_inst_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a synchronous instruction memory
// and hands each word to execute over a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | drive pc onto imem_addr with imem_rd_en high
// S_WAIT  | memory data valid; capture into ir or detect HALT
// S_HOLD  | ir_valid high until execute accepts; pc advances or branches
// S_HALT  | HALT opcode fetched; stopped until sys_rst
module inst_fetch_unit #(
  parameter int          ADDR_W  = 8,
  parameter logic [4:0]  HALT_OP = 5'd27
) (
  input  logic              clk,
  input  logic              sys_rst,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       instr_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic   handshake;
  logic   rdata_is_halt;

  assign handshake     = (state == S_HOLD) && ir_valid && ir_ready;
  assign rdata_is_halt = (imem_rdata[31:27] == HALT_OP);

  // Strobe is gated by reset so it reads low for as long as reset is held.
  assign imem_addr  = pc;
  assign imem_rd_en = (state == S_FETCH) && !sys_rst;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = rdata_is_halt ? S_HALT : S_HOLD;
      S_HOLD:  if (handshake) state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state       <= S_FETCH;
      pc          <= '0;
      ir          <= '0;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_WAIT: begin
          if (rdata_is_halt) begin
            halted <= 1'b1;
          end else begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (handshake) begin
            ir_valid <= 1'b0;
            pc       <= br_taken ? br_target : pc + PC_ONE;
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: cycle table, directed corner
// sequences, and a randomized run against a transaction-level model.
module tb_inst_fetch_unit;

  localparam logic [31:0] HALT_WORD = 32'hD800_0003;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_taken;
  logic [7:0]  br_target;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] instr_count;

  logic [31:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_unit #(.ADDR_W(8), .HALT_OP(5'd27)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_taken(br_taken), .br_target(br_target),
    .pc(pc), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  typedef struct {
    logic        rst, rdy, br;
    logic [7:0]  tgt;
    logic        e_rd;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [31:0] e_ir;
    logic [7:0]  e_pc;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic rdy, logic br, logic [7:0] tgt,
                              logic e_rd, logic [7:0] e_addr, logic e_valid,
                              logic [31:0] e_ir, logic [7:0] e_pc, logic e_halt,
                              logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.br = br; v.tgt = tgt;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid; v.e_ir = e_ir;
    v.e_pc = e_pc; v.e_halt = e_halt; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, outputs settle #1 later.
  task automatic cyc(input logic rst, input logic rdy, input logic br, input logic [7:0] tgt);
    @(negedge clk);
    sys_rst = rst; ir_ready = rdy; br_taken = br; br_target = tgt;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic fill_seq_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0001 + i;
  endtask

  vec_t vt [16];

  logic [7:0]  m_pc;
  logic [15:0] m_cnt;
  logic        m_halted;
  int exp_fetch_at, exp_valid_at, halt_due;
  int halt_rise, rd_after_halt, valid_on_halt;
  logic r, rdy, br;
  logic [7:0] tgt;
  logic [31:0] w;

  initial begin
    sys_rst = 1'b1; ir_ready = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    fill_seq_mem();

    vt[0]  = mk(1,0,0,8'h00, 0,8'h00,0,32'h0,        8'h00,0,16'd0);
    vt[1]  = mk(0,0,0,8'h00, 1,8'h00,0,32'h0,        8'h00,0,16'd0);
    vt[2]  = mk(0,0,0,8'h00, 0,8'h00,0,32'h0,        8'h00,0,16'd0);
    vt[3]  = mk(0,1,0,8'h00, 0,8'h00,1,32'h1000_0001,8'h00,0,16'd0);
    vt[4]  = mk(0,1,0,8'h00, 1,8'h01,0,32'h1000_0001,8'h01,0,16'd1);
    vt[5]  = mk(0,0,0,8'h00, 0,8'h01,0,32'h1000_0001,8'h01,0,16'd1);
    vt[6]  = mk(0,0,1,8'h80, 0,8'h01,1,32'h1000_0002,8'h01,0,16'd1);
    vt[7]  = mk(0,0,1,8'h80, 0,8'h01,1,32'h1000_0002,8'h01,0,16'd1);
    vt[8]  = mk(0,1,0,8'h00, 0,8'h01,1,32'h1000_0002,8'h01,0,16'd1);
    vt[9]  = mk(0,1,0,8'h00, 1,8'h02,0,32'h1000_0002,8'h02,0,16'd2);
    vt[10] = mk(0,1,0,8'h00, 0,8'h02,0,32'h1000_0002,8'h02,0,16'd2);
    vt[11] = mk(0,1,1,8'h40, 0,8'h02,1,32'h1000_0003,8'h02,0,16'd2);
    vt[12] = mk(0,1,0,8'h00, 1,8'h40,0,32'h1000_0003,8'h40,0,16'd3);
    vt[13] = mk(0,0,0,8'h00, 0,8'h40,0,32'h1000_0003,8'h40,0,16'd3);
    vt[14] = mk(1,0,0,8'h00, 0,8'h40,1,32'h1000_0041,8'h40,0,16'd3);
    vt[15] = mk(0,0,0,8'h00, 1,8'h00,0,32'h0,        8'h00,0,16'd0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(vt[i].rst, vt[i].rdy, vt[i].br, vt[i].tgt);
      check($sformatf("tbl%0d_rd_en", i),  {31'd0, imem_rd_en}, {31'd0, vt[i].e_rd});
      check($sformatf("tbl%0d_addr", i),   {24'd0, imem_addr},  {24'd0, vt[i].e_addr});
      check($sformatf("tbl%0d_valid", i),  {31'd0, ir_valid},   {31'd0, vt[i].e_valid});
      check($sformatf("tbl%0d_ir", i),     ir,                  vt[i].e_ir);
      check($sformatf("tbl%0d_pc", i),     {24'd0, pc},         {24'd0, vt[i].e_pc});
      check($sformatf("tbl%0d_halted", i), {31'd0, halted},     {31'd0, vt[i].e_halt});
      check($sformatf("tbl%0d_cnt", i),    {16'd0, instr_count},{16'd0, vt[i].e_cnt});
    end

    // Backpressure for 5 cycles, then wrap from 8'hFF to 8'h00
    do_reset();
    cyc(0,0,0,8'h00);
    cyc(0,0,0,8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(0,0,1,8'h77);
      check("bp_valid", {31'd0, ir_valid},   32'd1);
      check("bp_rd_en", {31'd0, imem_rd_en}, 32'd0);
      check("bp_ir",    ir,                  32'h1000_0001);
      check("bp_pc",    {24'd0, pc},         32'd0);
      check("bp_cnt",   {16'd0, instr_count},32'd0);
    end
    cyc(0,1,0,8'h00);
    cyc(0,0,0,8'h00);
    check("bp_resume_rd", {31'd0, imem_rd_en}, 32'd1);
    check("bp_resume_addr", {24'd0, imem_addr}, 32'd1);
    cyc(0,0,0,8'h00);
    cyc(0,1,1,8'hFF);
    cyc(0,0,0,8'h00);
    check("br_ff_rd", {31'd0, imem_rd_en}, 32'd1);
    check("br_ff_addr", {24'd0, imem_addr}, 32'hFF);
    cyc(0,0,0,8'h00);
    cyc(0,1,0,8'h00);
    check("wrap_ir", ir, 32'h1000_0100);
    cyc(0,0,0,8'h00);
    check("wrap_addr", {24'd0, imem_addr}, 32'd0);
    check("wrap_rd", {31'd0, imem_rd_en}, 32'd1);
    check("wrap_cnt", {16'd0, instr_count}, 32'd3);

    // HALT word at address 3
    mem[3] = HALT_WORD;
    do_reset();
    halt_rise = -1; rd_after_halt = 0; valid_on_halt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0,1,0,8'h00);
      if (halted && halt_rise < 0) halt_rise = i;
      if (i > 10 && imem_rd_en) rd_after_halt++;
      if (ir_valid && ir == HALT_WORD) valid_on_halt++;
    end
    check("halt_rise_cycle", halt_rise, 32'd11);
    check("halt_rd_after", rd_after_halt, 32'd0);
    check("halt_no_valid", valid_on_halt, 32'd0);
    check("halt_valid_low", {31'd0, ir_valid}, 32'd0);
    check("halt_pc", {24'd0, pc}, 32'd3);
    check("halt_cnt", {16'd0, instr_count}, 32'd3);
    cyc(1,0,0,8'h00);
    check("rst_halt_rd", {31'd0, imem_rd_en}, 32'd0);
    cyc(0,0,0,8'h00);
    check("rst_halt_halted", {31'd0, halted}, 32'd0);
    check("rst_halt_pc", {24'd0, pc}, 32'd0);
    check("rst_halt_ir", ir, 32'd0);
    check("rst_halt_cnt", {16'd0, instr_count}, 32'd0);
    check("rst_halt_rd_fetch", {31'd0, imem_rd_en}, 32'd1);
    check("rst_halt_addr", {24'd0, imem_addr}, 32'd0);
    mem[3] = 32'h1000_0004;

    // Randomized run against a transaction-level model
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if ($urandom_range(0, 49) == 0) w[31:27] = 5'd27;
      else if (w[31:27] == 5'd27) w[31:27] = 5'd0;
      mem[i] = w;
    end
    do_reset();
    m_pc = 8'h00; m_cnt = 16'd0; m_halted = 1'b0;
    exp_fetch_at = 0; exp_valid_at = -1; halt_due = -1;
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 299) == 0) || (m_halted && $urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      br  = ($urandom_range(0, 3) == 0);
      tgt = 8'($urandom);
      cyc(r, rdy, br, tgt);
      if (r) begin
        check("rnd_rst_rd", {31'd0, imem_rd_en}, 32'd0);
      end else begin
        if (exp_fetch_at == i) check("rnd_fetch_lat", {31'd0, imem_rd_en}, 32'd1);
        if (imem_rd_en) begin
          check("rnd_fetch_addr", {24'd0, imem_addr}, {24'd0, m_pc});
          check("rnd_fetch_novalid", {31'd0, ir_valid}, 32'd0);
          w = mem[m_pc];
          if (w[31:27] == 5'd27) halt_due = i + 2;
          else exp_valid_at = i + 2;
        end
        if (exp_valid_at == i) check("rnd_valid_lat", {31'd0, ir_valid}, 32'd1);
        if (halt_due == i) begin
          check("rnd_halt_rise", {31'd0, halted}, 32'd1);
          m_halted = 1'b1;
        end else if (!m_halted) begin
          check("rnd_not_halted", {31'd0, halted}, 32'd0);
        end
        if (m_halted) begin
          check("rnd_halt_rd", {31'd0, imem_rd_en}, 32'd0);
          check("rnd_halt_valid", {31'd0, ir_valid}, 32'd0);
          check("rnd_halt_pc", {24'd0, pc}, {24'd0, m_pc});
        end
        if (ir_valid) begin
          check("rnd_ir", ir, mem[m_pc]);
          check("rnd_pc", {24'd0, pc}, {24'd0, m_pc});
          check("rnd_cnt", {16'd0, instr_count}, {16'd0, m_cnt});
        end
      end
      if (r) begin
        m_pc = 8'h00; m_cnt = 16'd0; m_halted = 1'b0;
        exp_fetch_at = i + 1; exp_valid_at = -1; halt_due = -1;
      end else if (ir_valid && rdy) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_pc = br ? tgt : m_pc + 8'd1;
        exp_fetch_at = i + 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
